// File: rtl/mult2_acc.sv
// Accumulates products from the upstream multiplier, captured on busy's falling edge,
// and offers the total on a valid/ready handshake.
module mult2_acc #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int ACC_W = 2*WIDTH+LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_p,
    input  logic [LEN_W-1:0]   len,
    input  logic               mul_busy,
    input  logic [2*WIDTH-1:0] mul_o,
    output logic [ACC_W-1:0]   sum,
    output logic               sum_vld,
    input  logic               sum_rdy,
    output logic [LEN_W-1:0]   cnt,
    output logic               drop_p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               busy_q;
    logic [LEN_W-1:0]   len_q;
    logic               fall;
    logic [LEN_W-1:0]   cnt_inc;
    logic               take;

    assign fall    = busy_q & ~mul_busy;
    assign cnt_inc = cnt + 1'b1;
    assign take    = (state == ACC) & fall & ~clr_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // clr_p restarts from any state and outranks a pending handshake
    always_comb begin
        state_nx = state;
        if (clr_p) begin
            state_nx = (len == '0) ? HOLD : ACC;
        end else begin
            unique case (state)
                IDLE: state_nx = IDLE;
                ACC: begin
                    if (fall && cnt_inc == len_q) begin
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (sum_rdy) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        sum_vld = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            sum    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            drop_p <= 1'b0;
        end else begin
            busy_q <= mul_busy;
            drop_p <= fall & ~take;
            if (clr_p) begin
                sum   <= '0;
                cnt   <= '0;
                len_q <= len;
            end else if (take) begin
                sum <= sum + ACC_W'(mul_o);
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_mult2_acc.sv
// Self-checking bench for mult2_acc: vector table, directed corner sequences,
// and randomized traffic against a run-level reference model.
module tb_mult2_acc;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int ACC_W = 2*WIDTH+LEN_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr_p = 1'b0;
    logic [LEN_W-1:0]   len = '0;
    logic               mul_busy = 1'b0;
    logic [2*WIDTH-1:0] mul_o = '0;
    logic [ACC_W-1:0]   sum;
    logic               sum_vld;
    logic               sum_rdy = 1'b0;
    logic [LEN_W-1:0]   cnt;
    logic               drop_p;

    mult2_acc #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .clr_p(clr_p), .len(len),
        .mul_busy(mul_busy), .mul_o(mul_o), .sum(sum),
        .sum_vld(sum_vld), .sum_rdy(sum_rdy), .cnt(cnt), .drop_p(drop_p)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: a run is either collecting, finished-and-offered, or absent
    bit     m_collecting = 0;
    bit     m_offered = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    int     m_len = 0;
    bit     m_prev_busy = 0;
    bit     m_drop = 0;

    typedef struct {
        bit     clr;
        int     len;
        bit     busy;
        int     prod;
        bit     rdy;
        longint e_sum;
        bit     e_vld;
        int     e_cnt;
        bit     e_drop;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit c, input int l, input bit b,
                        input int p, input bit y);
        bit fall;
        @(negedge clk);
        rst = r; clr_p = c; len = l[LEN_W-1:0];
        mul_busy = b; mul_o = p[2*WIDTH-1:0]; sum_rdy = y;
        fall = m_prev_busy && !b;
        if (r) begin
            m_collecting = 0; m_offered = 0; m_sum = 0;
            m_cnt = 0; m_len = 0; m_prev_busy = 0; m_drop = 0;
        end else begin
            m_drop = fall && (c || !m_collecting);
            if (m_offered && y) m_offered = 0;
            if (c) begin
                m_sum = 0; m_cnt = 0; m_len = l % 16;
                m_collecting = (m_len != 0);
                m_offered = (m_len == 0);
            end else if (m_collecting && fall) begin
                m_sum += p % 65536;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_collecting = 0;
                    m_offered = 1;
                end
            end
            m_prev_busy = b;
        end
        @(posedge clk);
        #1;
        chk("sum", sum, m_sum);
        chk("sum_vld", sum_vld, m_offered);
        chk("cnt", cnt, m_cnt);
        chk("drop_p", drop_p, m_drop);
    endtask

    task automatic product(input int p, input bit y);
        step(0, 0, 0, 1, 0, y);
        step(0, 0, 0, 0, p, y);
    endtask

    initial begin
        tv[0]  = '{1, 3, 0, 0,     0, 0,     0, 0, 0};
        tv[1]  = '{0, 0, 1, 0,     0, 0,     0, 0, 0};
        tv[2]  = '{0, 0, 0, 200,   0, 200,   0, 1, 0};
        tv[3]  = '{0, 0, 1, 0,     0, 200,   0, 1, 0};
        tv[4]  = '{0, 0, 0, 15,    0, 215,   0, 2, 0};
        tv[5]  = '{0, 0, 1, 0,     0, 215,   0, 2, 0};
        tv[6]  = '{0, 0, 0, 65025, 0, 65240, 1, 3, 0};
        tv[7]  = '{0, 0, 0, 0,     1, 65240, 0, 3, 0};
        tv[8]  = '{0, 0, 1, 0,     0, 65240, 0, 3, 0};
        tv[9]  = '{0, 0, 0, 5,     0, 65240, 0, 3, 1};
        tv[10] = '{0, 0, 0, 0,     0, 65240, 0, 3, 0};

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_sum", sum, 0);
        chk("rst_vld", sum_vld, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_drop", drop_p, 0);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            step(0, tv[i].clr, tv[i].len, tv[i].busy, tv[i].prod, tv[i].rdy);
            chk($sformatf("tv%0d_sum", i), sum, tv[i].e_sum);
            chk($sformatf("tv%0d_vld", i), sum_vld, tv[i].e_vld);
            chk($sformatf("tv%0d_cnt", i), cnt, tv[i].e_cnt);
            chk($sformatf("tv%0d_drop", i), drop_p, tv[i].e_drop);
        end

        // full-length run of maximal products
        step(0, 1, 15, 0, 0, 0);
        for (int i = 0; i < 15; i++) product(65025, 0);
        chk("max_sum", sum, 975375);
        chk("max_vld", sum_vld, 1);
        chk("max_cnt", cnt, 15);
        step(0, 0, 0, 0, 0, 1);
        chk("max_ack", sum_vld, 0);

        // stall in offer, product arrives meanwhile
        step(0, 1, 1, 0, 0, 0);
        product(77, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        chk("stall_sum", sum, 77);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1234, 0);
        chk("stall_drop", drop_p, 1);
        chk("stall_keep", sum, 77);
        step(0, 0, 0, 0, 0, 0);
        chk("stall_drop_end", drop_p, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("stall_ack", sum_vld, 0);

        // abort mid-run and restart
        step(0, 1, 4, 0, 0, 0);
        product(11, 0);
        product(22, 0);
        step(0, 1, 2, 0, 0, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cnt", cnt, 0);
        product(42, 0);
        product(4, 0);
        chk("abort_res", sum, 46);
        chk("abort_vld", sum_vld, 1);
        step(0, 0, 0, 0, 0, 1);

        // zero-length run, then clear coincident with a fall
        step(0, 1, 0, 0, 0, 0);
        chk("len0_vld", sum_vld, 1);
        chk("len0_sum", sum, 0);
        step(0, 0, 0, 1, 0, 1);
        step(0, 1, 2, 0, 99, 0);
        chk("clrfall_drop", drop_p, 1);
        chk("clrfall_sum", sum, 0);
        product(3, 0);
        product(5, 0);
        chk("clrfall_res", sum, 8);
        step(0, 0, 0, 0, 0, 1);

        // reset mid-run
        step(0, 1, 4, 0, 0, 0);
        product(9, 0);
        product(9, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cnt", cnt, 0);
        product(50, 0);
        chk("midrst_drop", drop_p, 1);
        chk("midrst_sum2", sum, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 24) == 0),
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 65535)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
